// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file for the decode/issue stage.
// Each read port returns the stored value, or the value being written in the
// same cycle (write-to-read bypass). A pending-write scoreboard with one bit
// per register raises rd_busy on a port whose operand still waits for its
// producer, so that issue can stall. Reads can optionally go through a
// register stage. Register 0 can optionally be hardwired to zero.
// The register storage is a flop array rather than block RAM. This is needed
// because every register clears on reset and all read ports are read
// combinationally at the same time.
module regfile_mp_sb #(
    parameter int XLEN     = 32,  // data width of each register
    parameter int NREGS    = 32,  // number of architectural registers (2..2**AW)
    parameter int AW       = 5,   // address width
    parameter int NRD      = 2,   // number of read ports (1..4)
    parameter int RD_REG   = 0,   // 0: combinational read, 1: registered read (latency 1)
    parameter int ZERO_REG = 1    // 1: register 0 reads 0, ignores writes, never pending
) (
    input  logic                clk,
    input  logic                rst,      // asynchronous, active low
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic                flush
);

    // The register count is widened by one bit so that NREGS == 2**AW
    // still compares correctly against an AW-bit address.
    localparam logic [AW:0] NREGS_EXT = (AW+1)'(NREGS);
    localparam bit          HAS_ZERO  = (ZERO_REG != 0);

    // An address is usable if it names an implemented register.
    // Register 0 is excluded when it is hardwired to zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, a} < NREGS_EXT);
        is_zero  = (a == '0);
        return in_range && !(HAS_ZERO && is_zero);
    endfunction

    logic [XLEN-1:0] regs_reg [NREGS];
    logic [NREGS-1:0] pend_reg;
    logic [NREGS-1:0] pend_next;

    logic wr_ok;
    logic sb_ok;

    assign wr_ok = we && addr_ok(wr_addr);
    assign sb_ok = sb_set && addr_ok(sb_addr);

    // Architectural register storage: a single write port.
    // Invalid addresses never match wr_ok, so those writes are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_ok) begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_addr == AW'(i)) begin
                    regs_reg[i] <= wr_data;
                end
            end
        end
    end

    // Scoreboard next state. Flush beats everything.
    // Otherwise a newly issued producer (set) beats a writeback (clear)
    // to the same register.
    always_comb begin
        pend_next = pend_reg;
        if (flush) begin
            pend_next = '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (sb_ok && sb_addr == AW'(i)) begin
                    pend_next[i] = 1'b1;
                end else if (wr_ok && wr_addr == AW'(i)) begin
                    pend_next[i] = 1'b0;
                end
            end
        end
    end

    // Scoreboard state; clears immediately on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // Independent read ports; any number of them may name the same register.
    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
        logic [AW-1:0]   addr;
        logic            ok;
        logic            wr_hit;
        logic [XLEN-1:0] stored;
        logic            pend_hit;
        logic [XLEN-1:0] raw;

        assign addr   = rd_addr[gi*AW +: AW];
        assign ok     = addr_ok(addr);
        assign wr_hit = we && (wr_addr == addr);

        // Select the stored value and pending bit for this port's address.
        always_comb begin
            stored   = '0;
            pend_hit = 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                if (addr == AW'(i)) begin
                    stored   = regs_reg[i];
                    pend_hit = pend_reg[i];
                end
            end
        end

        // Choose the raw read value: zero for an invalid address,
        // the same-cycle write data on a bypass hit, else the stored value.
        always_comb begin
            raw = '0;
            if (ok) begin
                raw = wr_hit ? wr_data : stored;
            end
        end

        // Busy always follows the current address, whatever the read latency.
        // A same-cycle writeback hides the pending bit, matching the bypass.
        assign rd_busy[gi] = ok && pend_hit && !wr_hit;

        if (RD_REG != 0) begin : g_rdreg
            logic [XLEN-1:0] data_reg;

            // Registered read: capture the bypassed value at the clock edge.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_reg <= '0;
                end else begin
                    data_reg <= raw;
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = data_reg;
        end else begin : g_rdcomb
            assign rd_data[gi*XLEN +: XLEN] = raw;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb. It drives three instances in parallel:
//   dut0: defaults, combinational read
//   dut1: registered read, same stimulus as dut0
//   dut2: NREGS=16, NRD=3, combinational read; used for the out-of-range checks
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_addr = '0;
    logic        flush = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [14:0] rd_addr2 = '0;

    logic [63:0] rd_data0;
    logic [1:0]  rd_busy0;
    logic [63:0] rd_data1;
    logic [1:0]  rd_busy1;
    logic [95:0] rd_data2;
    logic [2:0]  rd_busy2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_mp_sb #(.RD_REG(0)) dut0 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush)
    );

    regfile_mp_sb #(.RD_REG(1)) dut1 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush)
    );

    regfile_mp_sb #(.NREGS(16), .NRD(3), .RD_REG(0)) dut2 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        sb;
        logic [4:0]  sa;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;   // {port1, port0}
    } vec_t;

    localparam int NV = 21;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; wr_addr = '0; wr_data = '0;
        sb_set = 1'b0; sb_addr = '0; flush = 1'b0;
    endtask

    initial begin
        logic [31:0] prev_d0;
        logic [31:0] prev_d1;

        //             we wa  wd            sb sa  fl ra0 ra1 d0            d1            busy
        vec[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0, 5,  0,  32'hDEADBEEF, 32'h0,        2'b00};
        vec[1]  = '{1, 0,  32'h00001234, 0, 0,  0, 5,  0,  32'hDEADBEEF, 32'h0,        2'b00};
        vec[2]  = '{0, 0,  32'h0,        0, 0,  0, 0,  5,  32'h0,        32'hDEADBEEF, 2'b00};
        vec[3]  = '{1, 7,  32'hA5A5A5A5, 0, 0,  0, 7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00};
        vec[4]  = '{0, 0,  32'h0,        1, 3,  0, 3,  7,  32'h0,        32'hA5A5A5A5, 2'b00};
        vec[5]  = '{0, 0,  32'h0,        0, 0,  0, 3,  3,  32'h0,        32'h0,        2'b11};
        vec[6]  = '{1, 3,  32'h00000042, 0, 0,  0, 3,  7,  32'h00000042, 32'hA5A5A5A5, 2'b00};
        vec[7]  = '{0, 0,  32'h0,        0, 0,  0, 3,  0,  32'h00000042, 32'h0,        2'b00};
        vec[8]  = '{0, 0,  32'h0,        1, 9,  0, 9,  3,  32'h0,        32'h00000042, 2'b00};
        vec[9]  = '{1, 9,  32'h99990000, 1, 9,  0, 9,  9,  32'h99990000, 32'h99990000, 2'b00};
        vec[10] = '{0, 0,  32'h0,        0, 0,  0, 9,  5,  32'h99990000, 32'hDEADBEEF, 2'b01};
        vec[11] = '{0, 0,  32'h0,        1, 1,  0, 1,  9,  32'h0,        32'h99990000, 2'b10};
        vec[12] = '{0, 0,  32'h0,        1, 2,  0, 1,  2,  32'h0,        32'h0,        2'b01};
        vec[13] = '{0, 0,  32'h0,        1, 31, 0, 2,  31, 32'h0,        32'h0,        2'b01};
        vec[14] = '{0, 0,  32'h0,        1, 4,  1, 31, 9,  32'h0,        32'h99990000, 2'b11};
        vec[15] = '{0, 0,  32'h0,        0, 0,  0, 4,  1,  32'h0,        32'h0,        2'b00};
        vec[16] = '{0, 0,  32'h0,        0, 0,  0, 2,  31, 32'h0,        32'h0,        2'b00};
        vec[17] = '{0, 0,  32'h0,        0, 0,  0, 9,  3,  32'h99990000, 32'h00000042, 2'b00};
        vec[18] = '{0, 0,  32'h0,        1, 0,  0, 0,  7,  32'h0,        32'hA5A5A5A5, 2'b00};
        vec[19] = '{0, 0,  32'h0,        0, 0,  0, 0,  0,  32'h0,        32'h0,        2'b00};
        vec[20] = '{1, 31, 32'hFFFFFFFF, 0, 0,  0, 31, 30, 32'hFFFFFFFF, 32'h0,        2'b00};

        // Reset state, sampled while reset is held.
        idle();
        #3;
        check("reset_busy0", 32'(rd_busy0), 32'h0);
        check("reset_busy1", 32'(rd_busy1), 32'h0);
        check("reset_rdreg_d0", rd_data1[31:0], 32'h0);
        check("reset_rdreg_d1", rd_data1[63:32], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table: dut0 checked combinationally in the vector's own cycle;
        // dut1 data shows the previous vector's value one cycle later.
        prev_d0 = '0;
        prev_d1 = '0;
        for (int i = 0; i < NV; i++) begin
            we = vec[i].we; wr_addr = vec[i].wa; wr_data = vec[i].wd;
            sb_set = vec[i].sb; sb_addr = vec[i].sa; flush = vec[i].fl;
            rd_addr = {vec[i].ra1, vec[i].ra0};
            @(negedge clk);
            check($sformatf("v%0d_d0", i), rd_data0[31:0], vec[i].d0);
            check($sformatf("v%0d_d1", i), rd_data0[63:32], vec[i].d1);
            check($sformatf("v%0d_busy", i), 32'(rd_busy0), 32'(vec[i].busy));
            check($sformatf("v%0d_busy_rdreg", i), 32'(rd_busy1), 32'(vec[i].busy));
            check($sformatf("v%0d_rdreg_d0", i), rd_data1[31:0], prev_d0);
            check($sformatf("v%0d_rdreg_d1", i), rd_data1[63:32], prev_d1);
            prev_d0 = vec[i].d0;
            prev_d1 = vec[i].d1;
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in mid-run: write x10, mark it pending, then reset between edges.
        idle();
        we = 1'b1; wr_addr = 5'd10; wr_data = 32'h0A0A0A0A; rd_addr = {5'd0, 5'd10};
        @(posedge clk); #1;
        idle();
        sb_set = 1'b1; sb_addr = 5'd10;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check("pre_rst_d0", rd_data0[31:0], 32'h0A0A0A0A);
        check("pre_rst_busy0", 32'(rd_busy0[0]), 32'h1);
        check("pre_rst_rdreg_d0", rd_data1[31:0], 32'h0A0A0A0A);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_d0", rd_data0[31:0], 32'h0);
        check("async_rst_busy", 32'(rd_busy0), 32'h0);
        check("async_rst_rdreg_d0", rd_data1[31:0], 32'h0);
        check("async_rst_busy_rdreg", 32'(rd_busy1), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        we = 1'b1; wr_addr = 5'd10; wr_data = 32'h00000055;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check("post_rst_write", rd_data0[31:0], 32'h00000055);
        @(posedge clk); #1;

        // 16-register instance: address 20 is out of range there but valid in dut0.
        we = 1'b1; wr_addr = 5'd20; wr_data = 32'hCAFEF00D;
        sb_set = 1'b1; sb_addr = 5'd20;
        rd_addr2 = {5'd4, 5'd20, 5'd20};
        rd_addr = {5'd0, 5'd20};
        @(negedge clk);
        check("nr16_oob_bypass_d0", rd_data2[31:0], 32'h0);
        check("nr16_oob_bypass_d1", rd_data2[63:32], 32'h0);
        check("dut0_a20_bypass", rd_data0[31:0], 32'hCAFEF00D);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check("nr16_oob_read", rd_data2[31:0], 32'h0);
        check("nr16_oob_busy", 32'(rd_busy2), 32'h0);
        check("dut0_a20_read", rd_data0[31:0], 32'hCAFEF00D);
        check("dut0_a20_busy", 32'(rd_busy0[0]), 32'h1);
        @(posedge clk); #1;
        we = 1'b1; wr_addr = 5'd15; wr_data = 32'h12345678;
        rd_addr2 = {5'd15, 5'd0, 5'd20};
        @(negedge clk);
        check("nr16_p2_bypass", rd_data2[95:64], 32'h12345678);
        @(posedge clk); #1;
        idle();
        rd_addr2 = {5'd0, 5'd15, 5'd0};
        @(negedge clk);
        check("nr16_p1_read", rd_data2[63:32], 32'h12345678);
        check("nr16_p2_x0", rd_data2[95:64], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-read-port integer register file with write-to-read bypass and a per-register pending-write scoreboard.
- Optional registered read stage and optional hardwired-zero register 0.
- Sits in the decode/issue stage of the RISC-V core: it supplies operands and flags operands whose producer has not yet written back, so issue can stall.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (2..2**AW)
AW, 5, address width
NRD, 2, number of read ports (1..4)
RD_REG, 0, 0 = combinational read; 1 = read data registered, latency 1
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never marked pending

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
rd_busy  out  NRD  port k operand has a pending (unwritten) producer
we  in  1  write enable
wr_addr  in  AW  write address
wr_data  in  XLEN  write data
sb_set  in  1  mark sb_addr pending (instruction with destination issued)
sb_addr  in  AW  destination register to mark pending
flush  in  1  clear all pending bits (pipeline flush)

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0; all pending bits = 0; with RD_REG=1, rd_data = 0. rd_busy = 0 while in reset.
- Valid address: addr < NREGS, and additionally addr != 0 when ZERO_REG=1.
  - Writes to invalid addresses are ignored.
  - sb_set to an invalid address is ignored.
  - Reads of an invalid address return 0 and busy = 0.
- Write: at posedge clk, if we and wr_addr is valid, reg[wr_addr] <= wr_data.
- Read value per port k (RAW):
  - If we and wr_addr == rd_addr_k and the address is valid, RAW = wr_data (bypass).
  - Otherwise RAW = reg[rd_addr_k].
  - Invalid address gives RAW = 0.
- RD_REG=0: rd_data_k = RAW combinationally. Zero-latency, same-cycle bypass.
- RD_REG=1: rd_data_k <= RAW at posedge. Data appears the cycle after the address is presented, and includes any write occurring in the address cycle.
- Ports are independent: any number may read the same address in the same cycle.
- Scoreboard: one pending bit per register, pend[i]. At posedge, in priority order:
  1. flush: all pend <= 0. sb_set in the same cycle is ignored.
  2. Otherwise, if we and wr_addr is valid: pend[wr_addr] <= 0.
  3. If sb_set and sb_addr is valid: pend[sb_addr] <= 1. When sb_addr == wr_addr, set wins over clear, because a new producer was issued.
- rd_busy_k (combinational, always from the current rd_addr_k, independent of RD_REG):
  - rd_busy_k = pend[rd_addr_k] and not (we and wr_addr == rd_addr_k).
  - The same-cycle writeback therefore de-asserts busy, consistent with the bypass.
- A write with no pending bit set is legal and simply updates the register.
- Reset asserted mid-operation clears registers and scoreboard immediately. The first write after release takes effect at the first posedge after rst=1.

Test Plan:
1. Reset with RD_REG=0, then write x5=0xDEADBEEF and read x5 next cycle -> rd_data0=0xDEADBEEF. Read x0 after writing x0=0x1234 -> 0, busy=0.
2. Bypass: in one cycle, we=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr0=rd_addr1=7 -> both ports read 0xA5A5A5A5 in that cycle (RD_REG=0), or on the next cycle (RD_REG=1).
3. Scoreboard: sb_set x3, then read x3 -> rd_busy0=1. Write x3=0x42 -> busy=0 in the write cycle and rd_data0=0x42 (bypass). Next cycle busy stays 0.
4. Simultaneous set and clear: pend[9]=1, then one cycle with we=1, wr_addr=9 and sb_set=1, sb_addr=9 -> following cycle rd_busy for x9 = 1, and reg9 holds the new data.
5. Flush: set pend on x1, x2, x31, then flush=1 together with sb_set x4 -> all busy=0, including x4. Register contents are unchanged.
6. Async reset mid-run: assert rst=0 between clock edges after writing x10 -> rd_data for x10 = 0 and all busy = 0 without waiting for a clock edge. Repeat with NREGS=16, NRD=3: a write to addr 20 is ignored and a read of 20 returns 0.
